// File: rtl/data_bus_arbiter_if.sv
// Two-master data-side bus bundle: master ports, shared bus, read return.
// slave = arbiter side, master = masters/decoder environment side.
interface data_bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wenable;
  logic        m0_gnt;
  logic [31:0] m0_rdata;
  logic        m0_rvalid;

  logic        m1_req;
  logic        m1_lock;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wenable;
  logic        m1_gnt;
  logic [31:0] m1_rdata;
  logic        m1_rvalid;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wenable;
  logic [31:0] bus_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_wenable,
    output m0_gnt, m0_rdata, m0_rvalid,
    input  m1_req, m1_lock, m1_addr, m1_wdata, m1_wenable,
    output m1_gnt, m1_rdata, m1_rvalid,
    output bus_addr, bus_wdata, bus_wenable,
    input  bus_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_wenable,
    input  m0_gnt, m0_rdata, m0_rvalid,
    output m1_req, m1_lock, m1_addr, m1_wdata, m1_wenable,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  bus_addr, bus_wdata, bus_wenable,
    output bus_rdata
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: M0 priority, M1 starvation guard and burst lock.
// Define ARB_ROUND_ROBIN_EN for alternating priority instead of fixed M0 priority.
module data_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned LOCK_MAX = 16
) (
  input logic          clk,
  input logic          rst,
  data_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  owner_t      owner_q, owner_d;
  logic [3:0]  wait_q, wait_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        locked_q, locked_d;
  logic        rd_q, rd_d;
  logic        lock_hold;
  logic        g0, g1;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_m1_q, last_m1_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      wait_q     <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      rd_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_m1_q  <= 1'b1;
`endif
    end else begin
      owner_q    <= owner_d;
      wait_q     <= wait_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      rd_q       <= rd_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_m1_q  <= last_m1_d;
`endif
    end
  end

  // owner_d is this cycle's grant; it becomes the registered owner.
  always_comb begin
    owner_d   = OWN_NONE;
    lock_hold = locked_q && bus.m1_req &&
                (lock_cnt_q < LOCK_LIM);
    if (rst)
      owner_d = OWN_NONE;
    else if (lock_hold)
      owner_d = OWN_M1;
`ifdef ARB_ROUND_ROBIN_EN
    else if (bus.m0_req && bus.m1_req)
      owner_d = last_m1_q ? OWN_M0 : OWN_M1;
`else
    else if (bus.m1_req && wait_q == WAIT_LIM)
      owner_d = OWN_M1;
`endif
    else if (bus.m0_req)
      owner_d = OWN_M0;
    else if (bus.m1_req)
      owner_d = OWN_M1;

    g0 = (owner_d == OWN_M0);
    g1 = (owner_d == OWN_M1);

    wait_d = '0;
    if (bus.m1_req && !g1)
      wait_d = (wait_q == WAIT_LIM) ? wait_q
                                    : wait_q + 4'd1;

    locked_d   = g1 && bus.m1_lock;
    lock_cnt_d = locked_d ? lock_cnt_q + 8'd1 : 8'd0;

    rd_d = (g0 && bus.m0_wenable == 4'b0) ||
           (g1 && bus.m1_wenable == 4'b0);

`ifdef ARB_ROUND_ROBIN_EN
    last_m1_d = last_m1_q;
    if (g1)
      last_m1_d = 1'b1;
    else if (g0)
      last_m1_d = 1'b0;
`endif
  end

  // Read return is suppressed while rst is high so an aborted read never answers.
  always_comb begin
    bus.m0_gnt      = g0;
    bus.m1_gnt      = g1;
    bus.bus_addr    = '0;
    bus.bus_wdata   = '0;
    bus.bus_wenable = '0;
    unique case (1'b1)
      g0: begin
        bus.bus_addr    = bus.m0_addr;
        bus.bus_wdata   = bus.m0_wdata;
        bus.bus_wenable = bus.m0_wenable;
      end
      g1: begin
        bus.bus_addr    = bus.m1_addr;
        bus.bus_wdata   = bus.m1_wdata;
        bus.bus_wenable = bus.m1_wenable;
      end
      default: ;
    endcase
    bus.m0_rvalid = !rst && rd_q && (owner_q == OWN_M0);
    bus.m1_rvalid = !rst && rd_q && (owner_q == OWN_M1);
    bus.m0_rdata  = bus.bus_rdata;
    bus.m1_rdata  = bus.bus_rdata;
  end

endmodule
